// File: rtl/ram_responder.sv
// Memory-side responder for the instruction-read / data-write RAM port.
// Fills the array with INIT_VALUE after reset, then serves pipelined reads and byte-enabled writes.
module ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [31:0] INIT_VALUE  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ready,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        addr_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LAT_W = RD_LATENCY;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     init_cnt_q, init_cnt_d;
  logic              ready_q, ready_d;
  logic [LAT_W-1:0]  valid_q, valid_d;
  logic [LAT_W-1:0]  err_q, err_d;
  logic [31:0]       data_q [LAT_W];
  logic [31:0]       data_d [LAT_W];
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              mem_we;
  logic [AW-1:0]     mem_widx;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wbe;
  logic              rd_fire;
  logic              wr_err;

  logic [AW-1:0]     rd_idx, wr_idx;
  logic              rd_oor, wr_oor;
  logic              unused_addr_lsbs;

  // Upper address bits select nothing: any set bit means out of range.
  assign rd_idx = rd_addr[AW+1:2];
  assign wr_idx = wr_addr[AW+1:2];
  assign rd_oor = |rd_addr[31:AW+2];
  assign wr_oor = |wr_addr[31:AW+2];
  assign unused_addr_lsbs = ^{rd_addr[1:0], wr_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    mem_we     = 1'b0;
    mem_widx   = wr_idx;
    mem_wdata  = wr_data;
    mem_wbe    = wr_be;
    rd_fire    = 1'b0;
    wr_err     = 1'b0;

    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_widx   = init_cnt_q;
        mem_wdata  = INIT_VALUE;
        mem_wbe    = 4'hF;
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      S_READY: begin
        rd_fire = rd_en;
        if (wr_en && (wr_be != 4'h0)) begin
          if (wr_oor) wr_err = 1'b1;
          else        mem_we = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Stage 0 samples the array before this edge's write lands.
    valid_d[0] = rd_fire;
    err_d[0]   = rd_fire & rd_oor;
    data_d[0]  = rd_oor ? 32'h0 : mem_q[rd_idx];
    for (int unsigned i = 1; i < LAT_W; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = data_q[i-1];
    end

    // Output stage keeps its data between responses and merges write errors.
    if (!valid_d[LAT_W-1]) data_d[LAT_W-1] = data_q[LAT_W-1];
    err_d[LAT_W-1] = (valid_d[LAT_W-1] & err_d[LAT_W-1]) | wr_err;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      valid_q    <= '0;
      err_q      <= '0;
      for (int unsigned i = 0; i < LAT_W; i++) data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < LAT_W; i++) data_q[i] <= data_d[i];
    end
  end

  // Array storage: no reset, contents established by the INIT sweep.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_wbe[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign ready    = ready_q;
  assign rd_valid = valid_q[LAT_W-1];
  assign rd_data  = data_q[LAT_W-1];
  assign addr_err = err_q[LAT_W-1];

endmodule
